// File: rtl/sram_core_if.sv
// Request/response bus for sram_core: shared address, byte-lane write mask,
// read/write strobes, write data and registered read data.
interface sram_core_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr_sel;
    logic [DATA_WIDTH/8-1:0] byte_sel;
    logic                    read_enable;
    logic                    write_enable;
    logic [DATA_WIDTH-1:0]   datain;
    logic [DATA_WIDTH-1:0]   dataout;

    modport master (
        output addr_sel, byte_sel, read_enable, write_enable, datain,
        input  dataout
    );

    modport slave (
        input  addr_sel, byte_sel, read_enable, write_enable, datain,
        output dataout
    );
endinterface

// File: rtl/sram_core.sv
// Single-port 2**ADDR_WIDTH x DATA_WIDTH memory, byte-lane writes, 1-cycle registered read.
// Define SRAM_WRITE_FWD_EN for write-first same-address read+write (default is read-first).
module sram_core #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    sram_core_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dataout_q;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] wr_word_d;
    logic [DATA_WIDTH-1:0] dataout_d;

    // Merge enabled lanes of datain over the currently stored word.
    always_comb begin
        old_word  = mem_q[bus.addr_sel];
        wr_word_d = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (bus.byte_sel[i]) begin
                wr_word_d[8*i +: 8] = bus.datain[8*i +: 8];
            end
        end
    end

`ifdef SRAM_WRITE_FWD_EN
    assign dataout_d = bus.write_enable ? wr_word_d : old_word;
`else
    assign dataout_d = old_word;
`endif

    // NOTE: the whole array is cleared in one reset cycle, so it must be built
    // from flops; a macro SRAM cannot do this and would need a clear sequencer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dataout_q <= '0;
        end else begin
            if (bus.write_enable) begin
                mem_q[bus.addr_sel] <= wr_word_d;
            end
            if (bus.read_enable) begin
                dataout_q <= dataout_d;
            end
        end
    end

    assign bus.dataout = dataout_q;
endmodule

// File: tb/tb_sram_core.sv
// Directed self-checking bench for sram_core; build with +define+SRAM_WRITE_FWD_EN
// to check the write-first variant.
module tb_sram_core;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sram_core_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

    sram_core #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        bus.byte_sel     = 4'b0000;
        bus.datain       = 32'h0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        bus.addr_sel     = a;
        bus.datain       = d;
        bus.byte_sel     = be;
        bus.write_enable = 1'b1;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [6:0] a);
        idle();
        bus.addr_sel    = a;
        bus.read_enable = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset            = 1'b0;
        bus.addr_sel     = 7'd3;
        bus.datain       = 32'hFFFF_FFFF;
        bus.byte_sel     = 4'b1111;
        bus.write_enable = 1'b1;
        bus.read_enable  = 1'b1;
        tick();
        reset = 1'b1;
        idle();
        checks++;
        if (bus.dataout !== 32'h0) begin
            failures++;
            $display("FAIL reset_dataout got=%h exp=%h", bus.dataout, 32'h0);
        end
        do_read(7'd0);
        checks++;
        if (bus.dataout !== 32'h0) begin
            failures++;
            $display("FAIL reset_read0 got=%h exp=%h", bus.dataout, 32'h0);
        end
        do_read(7'd3);
        checks++;
        if (bus.dataout !== 32'h0) begin
            failures++;
            $display("FAIL reset_write_ignored got=%h exp=%h", bus.dataout, 32'h0);
        end
    endtask

    task automatic test_full_write();
        do_write(7'd10, 32'hDEAD_BEEF, 4'b1111);
        do_read(7'd10);
        checks++;
        if (bus.dataout !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL full_write got=%h exp=%h", bus.dataout, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_byte_write();
        do_write(7'd10, 32'h1234_5678, 4'b0011);
        do_read(7'd10);
        checks++;
        if (bus.dataout !== 32'hDEAD_5678) begin
            failures++;
            $display("FAIL byte_low2 got=%h exp=%h", bus.dataout, 32'hDEAD_5678);
        end
        do_write(7'd10, 32'hC3C3_C3C3, 4'b1000);
        do_read(7'd10);
        checks++;
        if (bus.dataout !== 32'hC3AD_5678) begin
            failures++;
            $display("FAIL byte_lane3 got=%h exp=%h", bus.dataout, 32'hC3AD_5678);
        end
        do_write(7'd10, 32'h0000_0000, 4'b0000);
        do_read(7'd10);
        checks++;
        if (bus.dataout !== 32'hC3AD_5678) begin
            failures++;
            $display("FAIL byte_none got=%h exp=%h", bus.dataout, 32'hC3AD_5678);
        end
    endtask

    task automatic test_no_alias();
        do_write(7'd5, 32'hA5A5_A5A5, 4'b1111);
        do_write(7'd7, 32'h5A5A_5A5A, 4'b1111);
        do_read(7'd5);
        checks++;
        if (bus.dataout !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL alias_a5 got=%h exp=%h", bus.dataout, 32'hA5A5_A5A5);
        end
        do_read(7'd7);
        checks++;
        if (bus.dataout !== 32'h5A5A_5A5A) begin
            failures++;
            $display("FAIL alias_a7 got=%h exp=%h", bus.dataout, 32'h5A5A_5A5A);
        end
        do_write(7'd0, 32'h0BAD_F00D, 4'b1111);
        do_write(7'd127, 32'hCAFE_0127, 4'b1111);
        do_read(7'd0);
        checks++;
        if (bus.dataout !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL edge_addr0 got=%h exp=%h", bus.dataout, 32'h0BAD_F00D);
        end
        do_read(7'd127);
        checks++;
        if (bus.dataout !== 32'hCAFE_0127) begin
            failures++;
            $display("FAIL edge_addr127 got=%h exp=%h", bus.dataout, 32'hCAFE_0127);
        end
    endtask

    task automatic test_hold();
        do_read(7'd5);
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.addr_sel = 7'd7 + 7'(i);
            tick();
            checks++;
            if (bus.dataout !== 32'hA5A5_A5A5) begin
                failures++;
                $display("FAIL hold_cycle%0d got=%h exp=%h", i, bus.dataout, 32'hA5A5_A5A5);
            end
        end
    endtask

    task automatic test_rw_same_addr();
        logic [31:0] exp_rw;
`ifdef SRAM_WRITE_FWD_EN
        exp_rw = 32'h1111_1111;
`else
        exp_rw = 32'h5A5A_5A5A;
`endif
        idle();
        bus.addr_sel     = 7'd7;
        bus.datain       = 32'h1111_1111;
        bus.byte_sel     = 4'b1111;
        bus.write_enable = 1'b1;
        bus.read_enable  = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.dataout !== exp_rw) begin
            failures++;
            $display("FAIL rw_same got=%h exp=%h", bus.dataout, exp_rw);
        end
        do_read(7'd7);
        checks++;
        if (bus.dataout !== 32'h1111_1111) begin
            failures++;
            $display("FAIL rw_after got=%h exp=%h", bus.dataout, 32'h1111_1111);
        end
`ifdef SRAM_WRITE_FWD_EN
        exp_rw = 32'h1111_22BB;
`else
        exp_rw = 32'h1111_1111;
`endif
        idle();
        bus.addr_sel     = 7'd7;
        bus.datain       = 32'hAAAA_22BB;
        bus.byte_sel     = 4'b0011;
        bus.write_enable = 1'b1;
        bus.read_enable  = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.dataout !== exp_rw) begin
            failures++;
            $display("FAIL rw_partial got=%h exp=%h", bus.dataout, exp_rw);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        bus.addr_sel     = 7'd30;
        bus.datain       = 32'h3030_3030;
        bus.byte_sel     = 4'b1111;
        bus.write_enable = 1'b1;
        tick();
        bus.addr_sel     = 7'd31;
        bus.datain       = 32'h3131_3131;
        tick();
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b1;
        bus.addr_sel     = 7'd30;
        tick();
        checks++;
        if (bus.dataout !== 32'h3030_3030) begin
            failures++;
            $display("FAIL b2b_rd30 got=%h exp=%h", bus.dataout, 32'h3030_3030);
        end
        bus.addr_sel = 7'd31;
        tick();
        idle();
        checks++;
        if (bus.dataout !== 32'h3131_3131) begin
            failures++;
            $display("FAIL b2b_rd31 got=%h exp=%h", bus.dataout, 32'h3131_3131);
        end
    endtask

    task automatic test_mid_reset();
        do_write(7'd20, 32'h2020_2020, 4'b1111);
        do_read(7'd20);
        checks++;
        if (bus.dataout !== 32'h2020_2020) begin
            failures++;
            $display("FAIL midrst_pre got=%h exp=%h", bus.dataout, 32'h2020_2020);
        end
        idle();
        reset            = 1'b0;
        bus.addr_sel     = 7'd21;
        bus.datain       = 32'h2121_2121;
        bus.byte_sel     = 4'b1111;
        bus.write_enable = 1'b1;
        tick();
        reset = 1'b1;
        idle();
        checks++;
        if (bus.dataout !== 32'h0) begin
            failures++;
            $display("FAIL midrst_dataout got=%h exp=%h", bus.dataout, 32'h0);
        end
        do_read(7'd20);
        checks++;
        if (bus.dataout !== 32'h0) begin
            failures++;
            $display("FAIL midrst_cleared got=%h exp=%h", bus.dataout, 32'h0);
        end
        do_write(7'd22, 32'h2222_2222, 4'b1111);
        do_read(7'd21);
        checks++;
        if (bus.dataout !== 32'h0) begin
            failures++;
            $display("FAIL midrst_discard got=%h exp=%h", bus.dataout, 32'h0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.addr_sel = 7'd0;
        idle();
        #2;
        test_reset();
        test_full_write();
        test_byte_write();
        test_no_alias();
        test_hold();
        test_rw_same_addr();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
